// File: rtl/fetch_unit_if.sv
// Instruction-memory read port of the fetch stage: single-outstanding request/response.
interface fetch_unit_if #(
  parameter int WIDTH = 32
);
  logic             imem_req_out;
  logic [WIDTH-1:0] imem_addr_out;
  logic             imem_valid_in;
  logic [WIDTH-1:0] imem_rdata_in;

  modport master (
    output imem_req_out,
    output imem_addr_out,
    input  imem_valid_in,
    input  imem_rdata_in
  );

  modport slave (
    input  imem_req_out,
    input  imem_addr_out,
    output imem_valid_in,
    output imem_rdata_in
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem reads, pc/instr pairs to IF/ID.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
//
// state      | meaning
// S_ISSUE    | request imem at pc_q this cycle
// S_WAIT     | request outstanding, waiting for response
// S_HOLD     | response captured during stall, waiting for stall to fall
// S_DROP     | stale request outstanding, response will be discarded
// S_TDRAIN   | (trap build) stale request outstanding, then enter S_TRAP
// S_TRAP     | (trap build) misaligned redirect target, fetch halted
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] NOP      = WIDTH'(32'h0000_0013)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             stall_in,
  input  logic             redirect_in,
  input  logic [WIDTH-1:0] redirect_pc_in,
  fetch_unit_if.master     imem,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] instr_out,
  output logic             valid_out,
  output logic             misalign_out
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {S_ISSUE, S_WAIT, S_HOLD, S_DROP, S_TDRAIN, S_TRAP} state_t;
`else
  typedef enum logic [2:0] {S_ISSUE, S_WAIT, S_HOLD, S_DROP} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] pc_out_q, pc_out_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] tgt;
  logic             deliver;
  logic [WIDTH-1:0] del_data;
  logic             outstanding;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  logic misaligned;
  assign tgt        = redirect_pc_in;
  assign misaligned = |redirect_pc_in[1:0];
  assign misalign_out = misalign_q;
`else
  // Without the trap the low address bits are simply ignored.
  assign tgt          = redirect_pc_in & ~{{(WIDTH-2){1'b0}}, 2'b11};
  assign misalign_out = 1'b0;
`endif

  // A request is still in flight after this edge unless its response arrives now.
  always_comb begin
    outstanding = 1'b0;
    case (state_q)
      S_ISSUE:  outstanding = 1'b1;
      S_WAIT:   outstanding = !imem.imem_valid_in;
      S_DROP:   outstanding = !imem.imem_valid_in;
`ifdef FETCH_MISALIGN_TRAP_EN
      S_TDRAIN: outstanding = !imem.imem_valid_in;
`endif
      default:  outstanding = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    hold_d   = hold_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    deliver  = 1'b0;
    del_data = imem.imem_rdata_in;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif

    case (state_q)
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (imem.imem_valid_in) begin
          if (stall_in) begin
            hold_d  = imem.imem_rdata_in;
            state_d = S_HOLD;
          end else begin
            deliver = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_HOLD: begin
        if (!stall_in) begin
          deliver  = 1'b1;
          del_data = hold_q;
          state_d  = S_ISSUE;
        end
      end
      S_DROP: begin
        if (imem.imem_valid_in) state_d = S_ISSUE;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      S_TDRAIN: begin
        if (imem.imem_valid_in) state_d = S_TRAP;
      end
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_ISSUE;
    endcase

    if (deliver) begin
      pc_out_d = pc_q;
      instr_d  = del_data;
      valid_d  = 1'b1;
      pc_d     = pc_q + WIDTH'(4);
    end else if (!stall_in) begin
      valid_d = 1'b0;
      instr_d = NOP;
    end

    // Redirect overrides delivery, stall and any held data.
    if (redirect_in) begin
      pc_d     = tgt;
      pc_out_d = pc_out_q;
      valid_d  = 1'b0;
      instr_d  = NOP;
      state_d  = outstanding ? S_DROP : S_ISSUE;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_d = misaligned;
      if (misaligned) begin
        pc_out_d = tgt;
        state_d  = outstanding ? S_TDRAIN : S_TRAP;
      end
`endif
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= S_ISSUE;
      pc_q     <= RESET_PC;
      hold_q   <= '0;
      pc_out_q <= '0;
      instr_q  <= NOP;
      valid_q  <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      hold_q   <= hold_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign imem.imem_req_out  = (state_q == S_ISSUE) && rst_in;
  assign imem.imem_addr_out = pc_q;
  assign pc_out             = pc_out_q;
  assign instr_out          = instr_q;
  assign valid_out          = valid_q;

endmodule
